// File: rtl/serializer_pkg.sv
// serializer_pkg: shared state encoding and helpers for the sample scheduler.
`default_nettype none

package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } sched_state_t;

  localparam int DEFAULT_WORD_LENGTH = 16;

  function automatic int calc_div(input int sys, input int samp);
    return sys / samp;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// sample_fifo: small power-of-two sample buffer with extra-bit pointer wrap.
`default_nettype none

module sample_fifo #(
  parameter int WORD_LENGTH = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WORD_LENGTH-1:0]        wdata,
  output logic [WORD_LENGTH-1:0]        rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WORD_LENGTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  // A full FIFO never accepts, even when a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/serializer_scheduler.sv
// serializer_scheduler: paces buffered audio words into the PWM serializer,
// one word per sample tick, with silence substitution and overrun flagging.
`default_nettype none

module serializer_scheduler
  import serializer_pkg::*;
#(
  parameter int                     WORD_LENGTH        = DEFAULT_WORD_LENGTH,
  parameter int                     SYSTEM_FREQUENCY   = 100000000,
  parameter int                     SAMPLING_FREQUENCY = 1000000,
  parameter int                     FIFO_DEPTH         = 4,
  parameter logic [WORD_LENGTH-1:0] SILENCE_WORD       = '0
) (
  input  logic                         clock_i,
  input  logic                         reset_n_i,
  input  logic                         enable_i,
  input  logic                         sample_valid_i,
  input  logic [WORD_LENGTH-1:0]       sample_i,
  output logic                         sample_ready_o,
  output logic                         ser_enable_o,
  output logic [WORD_LENGTH-1:0]       ser_data_o,
  input  logic                         ser_done_i,
  output logic                         busy_o,
  output logic                         underrun_o,
  output logic                         overrun_o,
  output logic [7:0]                   underrun_count_o,
  output logic [$clog2(FIFO_DEPTH):0]  fill_level_o
);

  localparam int DIV = calc_div(SYSTEM_FREQUENCY, SAMPLING_FREQUENCY);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  generate
    if (DIV < WORD_LENGTH + 4) begin : g_div_check
      $error("serializer_scheduler: DIV too small for one word plus LOAD/GAP overhead");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
      $error("serializer_scheduler: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [CW-1:0]          count;
  logic                   tick;
  sched_state_t           state;
  sched_state_t           next_state;
  logic                   accept_tick;
  logic                   drop_tick;
  logic                   pop;
  logic                   push;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [WORD_LENGTH-1:0] fifo_head;

  assign sample_ready_o = !fifo_full;
  assign push           = sample_valid_i && !fifo_full;

  sample_fifo #(
    .WORD_LENGTH (WORD_LENGTH),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock_i),
    .rst_n (reset_n_i),
    .push  (push),
    .pop   (pop),
    .wdata (sample_i),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fill_level_o)
  );

  // Sample-rate divider; parked at zero whenever the scheduler is disabled.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (!enable_i) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (count == LAST);
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state  = state;
    accept_tick = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          next_state  = LOAD;
          accept_tick = 1'b1;
          pop         = !fifo_empty;
        end
      end
      LOAD:    next_state = SHIFT;
      SHIFT:   if (ser_done_i) next_state = GAP;
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    drop_tick = tick && (state != IDLE);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ser_enable_o     <= 1'b0;
      ser_data_o       <= '0;
      busy_o           <= 1'b0;
      underrun_o       <= 1'b0;
      overrun_o        <= 1'b0;
      underrun_count_o <= '0;
    end else begin
      ser_enable_o <= (next_state == SHIFT);
      busy_o       <= (next_state != IDLE);
      underrun_o   <= accept_tick && fifo_empty;
      overrun_o    <= drop_tick;
      if (accept_tick) begin
        ser_data_o <= fifo_empty ? SILENCE_WORD : fifo_head;
      end
      if (accept_tick && fifo_empty && (underrun_count_o != 8'hFF)) begin
        underrun_count_o <= underrun_count_o + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serializer_scheduler.sv
// tb_serializer_scheduler: directed stimulus with a word scoreboard checked by
// a monitor on each rising edge of ser_enable_o.
`default_nettype none

module tb_serializer_scheduler;

  localparam int WL = 16;

  logic          clock_i;
  logic          reset_n_i;
  logic          enable_i;
  logic          sample_valid_i;
  logic [WL-1:0] sample_i;
  logic          sample_ready_o;
  logic          ser_enable_o;
  logic [WL-1:0] ser_data_o;
  logic          ser_done_i;
  logic          busy_o;
  logic          underrun_o;
  logic          overrun_o;
  logic [7:0]    underrun_count_o;
  logic [2:0]    fill_level_o;

  serializer_scheduler #(
    .WORD_LENGTH        (WL),
    .SYSTEM_FREQUENCY   (20),
    .SAMPLING_FREQUENCY (1),
    .FIFO_DEPTH         (4),
    .SILENCE_WORD       (16'h0000)
  ) dut (
    .clock_i          (clock_i),
    .reset_n_i        (reset_n_i),
    .enable_i         (enable_i),
    .sample_valid_i   (sample_valid_i),
    .sample_i         (sample_i),
    .sample_ready_o   (sample_ready_o),
    .ser_enable_o     (ser_enable_o),
    .ser_data_o       (ser_data_o),
    .ser_done_i       (ser_done_i),
    .busy_o           (busy_o),
    .underrun_o       (underrun_o),
    .overrun_o        (overrun_o),
    .underrun_count_o (underrun_count_o),
    .fill_level_o     (fill_level_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc++;

  int            checks = 0;
  int            errors = 0;
  logic [WL-1:0] exp_q[$];
  int            done_delay = 16;
  bit            silence_mode = 1'b0;
  bit            spacing_en = 1'b0;
  int            last_rise = -1;
  int            first_rise = -1;
  int            last_under = -100;
  int            under_pulses = 0;
  int            over_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [WL-1:0] w);
    sample_valid_i = 1'b1;
    sample_i       = w;
    @(negedge clock_i);
    sample_valid_i = 1'b0;
  endtask

  // Serializer model: done pulses once after done_delay cycles of enable.
  initial begin : ser_model
    int en_cnt;
    en_cnt     = 0;
    ser_done_i = 1'b0;
    forever begin
      @(negedge clock_i);
      if (ser_enable_o === 1'b1) en_cnt++;
      else                       en_cnt = 0;
      ser_done_i = (ser_enable_o === 1'b1) && (en_cnt == done_delay);
    end
  end

  initial begin : monitor
    logic          prev_en;
    logic [WL-1:0] exp_w;
    logic [WL-1:0] held;
    prev_en = 1'b0;
    held    = '0;
    forever begin
      @(negedge clock_i);
      if (underrun_o === 1'b1) begin
        under_pulses++;
        last_under = cyc;
      end
      if (overrun_o === 1'b1) over_pulses++;
      if (ser_enable_o === 1'b1 && !prev_en) begin
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          check("ser_data_word", 32'(ser_data_o), 32'(exp_w));
        end else if (silence_mode) begin
          exp_w = '0;
          check("ser_data_silence", 32'(ser_data_o), 32'(exp_w));
        end else begin
          exp_w = ser_data_o;
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)", ser_data_o, $time);
        end
        if (spacing_en && last_rise >= 0) check("rise_spacing", 32'(cyc - last_rise), 32'd20);
        if (spacing_en && exp_w == '0) check("underrun_to_enable", 32'(cyc - last_under), 32'd1);
        if (first_rise < 0) first_rise = cyc;
        last_rise = cyc;
        held      = ser_data_o;
      end else if (ser_enable_o === 1'b1) begin
        check("ser_data_stable", 32'(ser_data_o), 32'(held));
      end
      prev_en = (ser_enable_o === 1'b1);
    end
  end

  initial begin : stimulus
    int en_cyc;
    int p;
    int highs;
    reset_n_i      = 1'b0;
    enable_i       = 1'b0;
    sample_valid_i = 1'b0;
    sample_i       = '0;
    repeat (3) @(negedge clock_i);

    // Reset state.
    check("rst_sample_ready", 32'(sample_ready_o), 32'd1);
    check("rst_ser_enable",   32'(ser_enable_o),   32'd0);
    check("rst_ser_data",     32'(ser_data_o),     32'd0);
    check("rst_busy",         32'(busy_o),         32'd0);
    check("rst_underrun",     32'(underrun_o),     32'd0);
    check("rst_overrun",      32'(overrun_o),      32'd0);
    check("rst_under_count",  32'(underrun_count_o), 32'd0);
    check("rst_fill",         32'(fill_level_o),   32'd0);
    reset_n_i = 1'b1;
    @(negedge clock_i);

    // Two buffered words, then three silence ticks.
    push_word(16'hA5A5);
    push_word(16'h1234);
    check("fill_after_two", 32'(fill_level_o), 32'd2);
    exp_q.push_back(16'hA5A5);
    exp_q.push_back(16'h1234);
    repeat (3) exp_q.push_back(16'h0000);
    spacing_en = 1'b1;
    first_rise = -1;
    en_cyc     = cyc;
    enable_i   = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() > 3; i++) @(negedge clock_i);
    check("two_words_sent", 32'(exp_q.size()), 32'd3);
    check("first_enable_latency", 32'(first_rise - en_cyc), 32'd22);
    check("no_underrun_yet", 32'(underrun_count_o), 32'd0);
    for (int i = 0; i < 100 && underrun_count_o != 8'd3; i++) @(negedge clock_i);
    check("under_count_3", 32'(underrun_count_o), 32'd3);
    enable_i = 1'b0;
    for (int i = 0; i < 100 && (exp_q.size() > 0 || busy_o); i++) @(negedge clock_i);
    check("silence_drained", 32'(exp_q.size()), 32'd0);
    check("under_pulses_3", 32'(under_pulses), 32'd3);
    spacing_en = 1'b0;

    // Fill the FIFO; fifth push is refused.
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    push_word(16'h4444);
    check("full_ready_low", 32'(sample_ready_o), 32'd0);
    check("full_level", 32'(fill_level_o), 32'd4);
    push_word(16'h5555);
    check("fifth_rejected", 32'(fill_level_o), 32'd4);
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333);
    exp_q.push_back(16'h4444);

    // Push coincident with the tick pop: refused while full, honoured otherwise.
    enable_i = 1'b1;
    repeat (20) @(negedge clock_i);
    sample_valid_i = 1'b1;
    sample_i       = 16'h5555;
    @(negedge clock_i);
    sample_valid_i = 1'b0;
    check("pop_full_push_refused", 32'(fill_level_o), 32'd3);
    check("ready_after_pop", 32'(sample_ready_o), 32'd1);
    repeat (19) @(negedge clock_i);
    sample_valid_i = 1'b1;
    sample_i       = 16'h6666;
    @(negedge clock_i);
    sample_valid_i = 1'b0;
    check("push_pop_level", 32'(fill_level_o), 32'd3);
    exp_q.push_back(16'h6666);

    // Slow serializer: the next tick lands in SHIFT and is dropped.
    done_delay = 25;
    repeat (20) @(negedge clock_i);
    check("overrun_pulse", 32'(overrun_o), 32'd1);
    check("overrun_no_pop", 32'(fill_level_o), 32'd3);
    check("overrun_in_shift", 32'(ser_enable_o), 32'd1);
    for (int i = 0; i < 60 && busy_o; i++) @(negedge clock_i);
    check("overrun_count", 32'(over_pulses), 32'd1);
    done_delay = 16;

    // Disable three cycles into SHIFT: word completes, then nothing more.
    for (int i = 0; i < 60 && !ser_enable_o; i++) @(negedge clock_i);
    check("shift_reached", 32'(ser_enable_o), 32'd1);
    repeat (3) @(negedge clock_i);
    enable_i = 1'b0;
    for (int i = 0; i < 40 && ser_enable_o; i++) @(negedge clock_i);
    check("gap_busy", 32'(busy_o), 32'd1);
    check("gap_enable_low", 32'(ser_enable_o), 32'd0);
    @(negedge clock_i);
    check("idle_after_gap", 32'(busy_o), 32'd0);
    highs = 0;
    repeat (60) begin
      @(negedge clock_i);
      if (ser_enable_o !== 1'b0 || busy_o !== 1'b0) highs++;
    end
    check("no_activity_disabled", 32'(highs), 32'd0);
    check("fill_kept", 32'(fill_level_o), 32'd2);
    check("under_count_kept", 32'(underrun_count_o), 32'd3);

    // Run dry until the underrun counter saturates.
    silence_mode = 1'b1;
    enable_i     = 1'b1;
    for (int i = 0; i < 6000 && underrun_count_o != 8'hFF; i++) @(negedge clock_i);
    check("under_count_255", 32'(underrun_count_o), 32'd255);
    @(negedge clock_i);
    p = under_pulses;
    repeat (60) @(negedge clock_i);
    check("under_count_saturated", 32'(underrun_count_o), 32'd255);
    check("under_pulses_after_sat", 32'(under_pulses - p), 32'd3);

    // Asynchronous reset in the middle of SHIFT.
    for (int i = 0; i < 40 && !ser_enable_o; i++) @(negedge clock_i);
    repeat (3) @(negedge clock_i);
    check("pre_reset_shift", 32'(ser_enable_o), 32'd1);
    #2;
    reset_n_i = 1'b0;
    enable_i  = 1'b0;
    #1;
    check("async_rst_enable", 32'(ser_enable_o), 32'd0);
    check("async_rst_fill", 32'(fill_level_o), 32'd0);
    check("async_rst_count", 32'(underrun_count_o), 32'd0);
    check("async_rst_busy", 32'(busy_o), 32'd0);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    repeat (3) @(negedge clock_i);
    check("post_rst_idle", 32'(ser_enable_o), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
